// File: rtl/hazard_ctrl_if.sv
// Hazard controller signal bundle: pipeline register indices and control
// bits going in, stall/flush/forward controls coming back out.
interface hazard_ctrl_if;
    logic [4:0] rs_d, rt_d, rs_e, rt_e;
    logic [4:0] write_reg_e, write_reg_m, write_reg_w;
    logic       reg_write_e, reg_write_m, reg_write_w;
    logic       mem_to_reg_e, mem_to_reg_m;
    logic       branch_d, pc_src_d, jump_d;
    logic       md_start_e;
    logic       imem_ready;

    logic       stall_f, stall_d, stall_e;
    logic       flush_d, flush_e, flush_m;
    logic       forward_a_d, forward_b_d;
    logic [1:0] forward_a_e, forward_b_e;
    logic       md_busy, md_done;

    // Pipeline datapath side: supplies stage state, consumes controls.
    modport master (
        output rs_d, rt_d, rs_e, rt_e, write_reg_e, write_reg_m, write_reg_w,
               reg_write_e, reg_write_m, reg_write_w, mem_to_reg_e, mem_to_reg_m,
               branch_d, pc_src_d, jump_d, md_start_e, imem_ready,
        input  stall_f, stall_d, stall_e, flush_d, flush_e, flush_m,
               forward_a_d, forward_b_d, forward_a_e, forward_b_e, md_busy, md_done
    );

    // Hazard controller side.
    modport slave (
        input  rs_d, rt_d, rs_e, rt_e, write_reg_e, write_reg_m, write_reg_w,
               reg_write_e, reg_write_m, reg_write_w, mem_to_reg_e, mem_to_reg_m,
               branch_d, pc_src_d, jump_d, md_start_e, imem_ready,
        output stall_f, stall_d, stall_e, flush_d, flush_e, flush_m,
               forward_a_d, forward_b_d, forward_a_e, forward_b_e, md_busy, md_done
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage MIPS32 pipeline.
// Load-use and branch-operand stalls, D/E forwarding selects, mult/div
// occupancy of E (IDLE/BUSY FSM with a down-counter) and fetch wait states.
module hazard_ctrl #(
    parameter int MD_LATENCY = 4,
    parameter int CNT_W      = $clog2(MD_LATENCY)
) (
    input  logic         clk,
    input  logic         rst_n,
    hazard_ctrl_if.slave hz
);

    typedef enum logic {IDLE, BUSY} md_state_e;

    md_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             md_stall;
    logic             md_done_c;
    logic             lw_stall, branch_stall, redirect, stall_d_c;

    // Register 0 is hardwired zero, so it never creates a dependency.
    function automatic logic hit(input logic [4:0] r, input logic [4:0] w);
        return (r != 5'd0) && (r == w);
    endfunction

    function automatic logic [1:0] fwd_e(input logic [4:0] r);
        if (hit(r, hz.write_reg_m) && hz.reg_write_m)      return 2'b10;
        else if (hit(r, hz.write_reg_w) && hz.reg_write_w) return 2'b01;
        else                                               return 2'b00;
    endfunction

    // Mult/div state register; reset drops any in-flight occupancy at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Mult/div sequencing: load LATENCY-1 on start, count down while holding
    // E, and spend the cnt==0 cycle releasing the stall and pulsing done.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        md_stall  = 1'b0;
        md_done_c = 1'b0;
        case (state_q)
            IDLE: begin
                if (hz.md_start_e) begin
                    md_stall = 1'b1;
                    state_d  = BUSY;
                    cnt_d    = CNT_W'(MD_LATENCY - 1);
                end
            end
            BUSY: begin
                if (cnt_q != '0) begin
                    md_stall = 1'b1;
                    cnt_d    = cnt_q - CNT_W'(1);
                end else begin
                    // md_start_e still belongs to the finishing instruction
                    md_done_c = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Stall, flush and forwarding decode from current stage contents.
    always_comb begin
        lw_stall     = hz.mem_to_reg_e & hz.reg_write_e &
                       (hit(hz.rs_d, hz.write_reg_e) | hit(hz.rt_d, hz.write_reg_e));
        branch_stall = hz.branch_d &
                       ((hz.reg_write_e &
                         (hit(hz.rs_d, hz.write_reg_e) | hit(hz.rt_d, hz.write_reg_e))) |
                        (hz.mem_to_reg_m &
                         (hit(hz.rs_d, hz.write_reg_m) | hit(hz.rt_d, hz.write_reg_m))));
        stall_d_c    = lw_stall | branch_stall | md_stall;
        // a redirect is only honoured once D is free to move
        redirect     = (hz.pc_src_d | hz.jump_d) & ~stall_d_c;

        hz.stall_d     = stall_d_c;
        hz.stall_e     = md_stall;
        hz.stall_f     = stall_d_c | (~hz.imem_ready & ~redirect);
        hz.flush_d     = ~stall_d_c & (redirect | ~hz.imem_ready);
        // no bubble into E while E itself is held by mult/div
        hz.flush_e     = (lw_stall | branch_stall) & ~md_stall;
        hz.flush_m     = md_stall;
        hz.forward_a_d = hit(hz.rs_d, hz.write_reg_m) & hz.reg_write_m;
        hz.forward_b_d = hit(hz.rt_d, hz.write_reg_m) & hz.reg_write_m;
        hz.forward_a_e = fwd_e(hz.rs_e);
        hz.forward_b_e = fwd_e(hz.rt_e);
        hz.md_busy     = (state_q == BUSY);
        hz.md_done     = md_done_c;
    end

endmodule
